// File: rtl/score_display_renderer_if.sv
// Score / pixel bus between the frame pipeline and the seven-segment score renderer.
interface score_display_renderer_if #(
  parameter int unsigned SCORE_W = 7,
  parameter int unsigned COORD_W = 12
);
  logic               score_valid;
  logic [SCORE_W-1:0] score_in;
  logic               score_ready;
  logic [COORD_W-1:0] origin_x;
  logic [COORD_W-1:0] origin_y;
  logic               frame_start;
  logic               blink_en;
  logic               pix_valid;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               pix_on_valid;
  logic               pix_on;

  modport master (
    output score_valid, score_in, origin_x, origin_y, frame_start, blink_en,
    output pix_valid, pix_x, pix_y,
    input  score_ready, pix_on_valid, pix_on
  );

  modport slave (
    input  score_valid, score_in, origin_x, origin_y, frame_start, blink_en,
    input  pix_valid, pix_x, pix_y,
    output score_ready, pix_on_valid, pix_on
  );
endinterface

// File: rtl/score_display_renderer.sv
// Seven-segment score renderer: serial double-dabble conversion, frame-synchronous
// commit, leading-zero blanking, saturation, blink, and a 2-stage per-pixel hit pipeline.
module score_display_renderer #(
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned SCORE_W      = 7,
  parameter int unsigned COORD_W      = 12,
  parameter int unsigned SEG_W        = 100,
  parameter int unsigned SEG_H        = 100,
  parameter int unsigned SEG_T        = 10,
  parameter int unsigned DIGIT_PITCH  = 160,
  parameter int unsigned BLANK_LZ     = 1,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input logic clk,
  input logic rst,
  score_display_renderer_if.slave bus
);

  localparam int unsigned DigW   = 4 * NUM_DIGITS;
  localparam int unsigned CntW   = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned Limit  = 10 ** NUM_DIGITS;

  typedef enum logic [1:0] {StIdle, StConv, StPend} state_e;
  // Two guard bits keep segment centres above/left of the origin from wrapping.
  typedef logic signed [COORD_W+1:0] coord_t;

  localparam coord_t HalfW = coord_t'(SEG_W / 2);
  localparam coord_t HalfH = coord_t'(SEG_H / 2);
  localparam coord_t HalfT = coord_t'(SEG_T / 2);
  localparam coord_t SegH  = coord_t'(SEG_H);

  function automatic logic in_box(coord_t px, coord_t py, coord_t sx, coord_t sy,
                                  coord_t hw, coord_t hh);
    coord_t dx, dy;
    dx = px - sx;
    dy = py - sy;
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return (dx <= hw) && (dy <= hh);
  endfunction

  // Bit 0 = segment a ... bit 6 = segment g.
  function automatic logic [6:0] seg_hits(coord_t px, coord_t py, coord_t cx, coord_t cy);
    logic [6:0] h;
    h[0] = in_box(px, py, cx,         cy - SegH,  HalfW, HalfT);
    h[1] = in_box(px, py, cx + HalfW, cy - HalfH, HalfT, HalfH);
    h[2] = in_box(px, py, cx + HalfW, cy + HalfH, HalfT, HalfH);
    h[3] = in_box(px, py, cx,         cy + SegH,  HalfW, HalfT);
    h[4] = in_box(px, py, cx - HalfW, cy + HalfH, HalfT, HalfH);
    h[5] = in_box(px, py, cx - HalfW, cy - HalfH, HalfT, HalfH);
    h[6] = in_box(px, py, cx,         cy,         HalfW, HalfT);
    return h;
  endfunction

  function automatic logic [6:0] seg_decode(logic [3:0] d);
    logic [6:0] m;
    unique case (d)
      4'd0:    m = 7'b0111111;
      4'd1:    m = 7'b0000110;
      4'd2:    m = 7'b1011011;
      4'd3:    m = 7'b1001111;
      4'd4:    m = 7'b1100110;
      4'd5:    m = 7'b1101101;
      4'd6:    m = 7'b1111101;
      4'd7:    m = 7'b0000111;
      4'd8:    m = 7'b1111111;
      4'd9:    m = 7'b1101111;
      default: m = 7'b0000000;
    endcase
    return m;
  endfunction

  state_e                   state_q, state_d;
  logic [SCORE_W-1:0]       bin_q;
  logic [DigW-1:0]          bcd_q, bcd_adj, disp_q;
  logic [CntW-1:0]          cnt_q;
  logic                     sat_q;
  logic [BlinkW-1:0]        blink_cnt_q;
  logic                     phase_q;
  logic [7*NUM_DIGITS-1:0]  hit_d, hit_q;
  logic                     pv_q, pix_on_valid_q, pix_on_q;
  logic                     lit, lead;
  logic [3:0]               dig;
  logic [6:0]               mask;
  coord_t                   px, py, ox, oy;

  assign px = coord_t'({2'b00, bus.pix_x});
  assign py = coord_t'({2'b00, bus.pix_y});
  assign ox = coord_t'({2'b00, bus.origin_x});
  assign oy = coord_t'({2'b00, bus.origin_y});

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next state: accept, convert for SCORE_W cycles, wait for a frame boundary.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.score_valid) state_d = StConv;
      StConv:  if (cnt_q == CntW'(SCORE_W - 1)) state_d = StPend;
      StPend:  if (bus.frame_start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.score_ready = (state_q == StIdle);
  end

  // Double-dabble add-3 correction on every BCD digit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int j = 0; j < int'(NUM_DIGITS); j++) begin
      if (bcd_q[4*j +: 4] >= 4'd5) bcd_adj[4*j +: 4] = bcd_q[4*j +: 4] + 4'd3;
    end
  end

  // Conversion datapath: latch on accept, then shift one binary bit per CONV cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (state_q == StIdle && bus.score_valid) begin
      bin_q <= bus.score_in;
      bcd_q <= '0;
      cnt_q <= '0;
      sat_q <= (32'(bus.score_in) >= Limit);
    end else if (state_q == StConv) begin
      bin_q <= bin_q << 1;
      bcd_q <= {bcd_adj[DigW-2:0], bin_q[SCORE_W-1]};
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Display commit and blink phase; both only move on frame_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      if (state_q == StPend && bus.frame_start) begin
        disp_q <= sat_q ? {NUM_DIGITS{4'd9}} : bcd_q;
      end
      if (!bus.blink_en) begin
        blink_cnt_q <= '0;
        phase_q     <= 1'b0;
      end else if (bus.frame_start) begin
        if (blink_cnt_q == BlinkW'(BLINK_FRAMES - 1)) begin
          blink_cnt_q <= '0;
          phase_q     <= ~phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BlinkW'(1);
        end
      end
    end
  end

  // Stage 1 geometry: raw segment hits for every digit.
  always_comb begin
    hit_d = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      hit_d[7*i +: 7] = seg_hits(px, py, ox + coord_t'(i * int'(DIGIT_PITCH)), oy);
    end
  end

  // Stage 2 masking: decoded segments with leading-zero blanking, OR-reduced.
  always_comb begin
    lit  = 1'b0;
    lead = 1'b1;
    dig  = '0;
    mask = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      dig  = disp_q[4*(int'(NUM_DIGITS) - 1 - i) +: 4];
      mask = seg_decode(dig);
      if ((BLANK_LZ != 0) && lead && (dig == 4'd0) && (i < int'(NUM_DIGITS) - 1)) mask = '0;
      if (dig != 4'd0) lead = 1'b0;
      lit = lit | (|(hit_q[7*i +: 7] & mask));
    end
  end

  // Pixel pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q          <= '0;
      pv_q           <= 1'b0;
      pix_on_valid_q <= 1'b0;
      pix_on_q       <= 1'b0;
    end else begin
      hit_q          <= hit_d;
      pv_q           <= bus.pix_valid;
      pix_on_valid_q <= pv_q;
      pix_on_q       <= pv_q & lit & ~phase_q;
    end
  end

  assign bus.pix_on_valid = pix_on_valid_q;
  assign bus.pix_on       = pix_on_q;

endmodule

// File: tb/tb_score_display_renderer.sv
// Bench for score_display_renderer: directed steps plus random scores and pixel streams,
// checked against an arithmetic model of the digits, segments and blink counter.
module tb_score_display_renderer;

  localparam int ND = 2;
  localparam int SW = 7;
  localparam int CW = 12;
  localparam int BF = 2;
  localparam int MASKC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  score_display_renderer_if #(.SCORE_W(SW), .COORD_W(CW)) bus ();

  score_display_renderer #(.BLINK_FRAMES(BF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  // Reference model state.
  string seg_str [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg",
                          "abc", "abcdefg", "abcdfg"};
  int m_score = 0, m_pend_score = 0, m_acc = 0, m_bcnt = 0, m_ox = 300, m_oy = 200;
  bit m_pend = 0, m_phase = 0, m_blink_en = 0;

  function automatic int iabs(int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic bit model_pix(int px, int py);
    int v, d, cx, cy, sx, sy;
    bit lead, hit, horiz;
    string s;
    if (m_phase) return 1'b0;
    v = (m_score >= 10 ** ND) ? 10 ** ND - 1 : m_score;
    lead = 1'b1;
    hit  = 1'b0;
    for (int i = 0; i < ND; i++) begin
      d = (v / (10 ** (ND - 1 - i))) % 10;
      if (lead && d == 0 && i < ND - 1) continue;
      lead = 1'b0;
      cx = m_ox + i * 160;
      cy = m_oy;
      s  = seg_str[d];
      for (int k = 0; k < s.len(); k++) begin
        sx = cx; sy = cy; horiz = 1'b0;
        case (s[k])
          "a": begin sy = cy - 100; horiz = 1'b1; end
          "b": begin sx = cx + 50; sy = cy - 50; end
          "c": begin sx = cx + 50; sy = cy + 50; end
          "d": begin sy = cy + 100; horiz = 1'b1; end
          "e": begin sx = cx - 50; sy = cy + 50; end
          "f": begin sx = cx - 50; sy = cy - 50; end
          default: horiz = 1'b1;
        endcase
        if (horiz) hit |= (iabs(px - sx) <= 50) && (iabs(py - sy) <= 5);
        else       hit |= (iabs(px - sx) <= 5) && (iabs(py - sy) <= 50);
      end
    end
    return hit;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_score(input int s);
    @(negedge clk);
    bus.score_valid = 1'b1;
    bus.score_in    = SW'(s);
    @(posedge clk);
    #1;
    bus.score_valid = 1'b0;
    if (!m_pend) begin
      m_pend = 1'b1;
      m_pend_score = s;
      m_acc = cyc;
    end
  endtask

  task automatic frame();
    int fc;
    @(negedge clk);
    bus.frame_start = 1'b1;
    fc = cyc + 1;
    if (m_pend && (fc - m_acc) >= SW + 1) begin
      m_score = m_pend_score;
      m_pend  = 1'b0;
    end
    if (m_blink_en) begin
      m_bcnt++;
      if (m_bcnt == BF) begin
        m_bcnt  = 0;
        m_phase = ~m_phase;
      end
    end
    @(posedge clk);
    #1;
    bus.frame_start = 1'b0;
  endtask

  task automatic set_blink(input bit b);
    @(negedge clk);
    bus.blink_en = b;
    @(posedge clk);
    #1;
    m_blink_en = b;
    if (!b) begin
      m_bcnt  = 0;
      m_phase = 1'b0;
    end
  endtask

  task automatic set_origin(input int x, input int y);
    @(negedge clk);
    bus.origin_x = CW'(x);
    bus.origin_y = CW'(y);
    m_ox = x;
    m_oy = y;
  endtask

  task automatic check_pixel(input string tag, input int x, input int y);
    bit e;
    x = x & MASKC;
    y = y & MASKC;
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_x = CW'(x);
    bus.pix_y = CW'(y);
    e = model_pix(x, y);
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, bus.pix_on_valid, 1);
    chk(tag, bus.pix_on, e);
  endtask

  // One pixel per cycle; output at negedge N+2 belongs to the pixel driven at negedge N.
  task automatic stream(input int n);
    bit qv[$];
    bit qo[$];
    bit v;
    int x, y;
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      if (qv.size() == 2) begin
        chk("stream_valid", bus.pix_on_valid, qv.pop_front());
        chk("stream_on", bus.pix_on, qo.pop_front());
      end
      if (k < n) begin
        v = ($urandom_range(0, 3) != 0);
        x = (m_ox - 80 + int'($urandom_range(0, ND * 160))) & MASKC;
        y = (m_oy - 120 + int'($urandom_range(0, 240))) & MASKC;
        bus.pix_valid = v;
        bus.pix_x = CW'(x);
        bus.pix_y = CW'(y);
        qv.push_back(v);
        qo.push_back(v && model_pix(x, y));
      end else begin
        bus.pix_valid = 1'b0;
        qv.push_back(1'b0);
        qo.push_back(1'b0);
      end
    end
  endtask

  task automatic commit(input int s);
    send_score(s);
    wait_cycles(SW + 2);
    chk("ready_pend", bus.score_ready, 0);
    frame();
    chk("ready_idle", bus.score_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.score_valid = 1'b0;
    bus.score_in    = '0;
    bus.origin_x    = CW'(m_ox);
    bus.origin_y    = CW'(m_oy);
    bus.frame_start = 1'b0;
    bus.blink_en    = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_x       = '0;
    bus.pix_y       = '0;
    wait_cycles(3);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", bus.score_ready, 1);
    chk("reset_valid", bus.pix_on_valid, 0);
    chk("reset_on", bus.pix_on, 0);

    // Score 42: digit 0 shows 4, its middle segment covers the origin.
    commit(42);
    check_pixel("s42_origin", 300, 200);
    check_pixel("s42_d1_top", 460, 100);
    stream(40);

    // Score 7: leading zero blanked, 7 has a top but no middle segment.
    commit(7);
    check_pixel("s7_d0_mid", 300, 200);
    check_pixel("s7_d0_top", 300, 100);
    check_pixel("s7_d1_mid", 460, 200);
    check_pixel("s7_d1_top", 460, 100);
    stream(40);

    // Score 100 saturates to 99; ready stays low until the frame boundary.
    send_score(100);
    for (int k = 0; k < SW + 6; k++) begin
      chk("sat_ready_low", bus.score_ready, 0);
      wait_cycles(1);
    end
    frame();
    chk("sat_ready_high", bus.score_ready, 1);
    check_pixel("s100_d0_mid", 300, 200);
    check_pixel("s100_d0_b", 350, 150);
    stream(30);

    // frame_start on the CONV->PEND edge must not commit.
    send_score(55);
    wait_cycles(6);
    frame();
    chk("edge_frame_ready", bus.score_ready, 0);
    check_pixel("edge_frame_b", 350, 150);
    frame();
    chk("late_frame_ready", bus.score_ready, 1);
    check_pixel("s55_d0_b", 350, 150);

    // Blink: phase flips every BF frames; commit and toggle together on one frame.
    set_blink(1'b1);
    for (int k = 0; k < 6; k++) begin
      frame();
      check_pixel("blink_d1_mid", 460, 200);
    end
    send_score(88);
    wait_cycles(SW + 2);
    frame();
    check_pixel("blink_commit_d0", 300, 200);
    frame();
    check_pixel("blink_commit_d0b", 300, 200);
    set_blink(1'b0);
    check_pixel("blink_off", 300, 200);

    // Random scores with random pixel streams.
    for (int r = 0; r < 6; r++) begin
      commit(int'($urandom_range(0, (1 << SW) - 1)));
      stream(30);
    end

    // Near the top edge: centres above 0 must not wrap onto row 4095.
    set_origin(100, 40);
    commit(88);
    check_pixel("edge_y4095", 100, 4095);
    check_pixel("edge_y0_mid", 100, 0);
    check_pixel("edge_y0_f", 50, 0);
    check_pixel("edge_x4095", 4095, 40);
    stream(40);

    // Reset during conversion aborts it and clears the display.
    set_origin(300, 200);
    send_score(33);
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_x = CW'(300);
    bus.pix_y = CW'(200);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("prerst_valid", bus.pix_on_valid, 1);
    rst = 1'b1;
    #2;
    chk("rst_ready", bus.score_ready, 1);
    chk("rst_valid", bus.pix_on_valid, 0);
    chk("rst_on", bus.pix_on, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.pix_valid = 1'b0;
    m_score = 0;
    m_pend  = 1'b0;
    m_bcnt  = 0;
    m_phase = 1'b0;
    wait_cycles(SW + 3);
    chk("rst_no_commit_ready", bus.score_ready, 1);
    frame();
    check_pixel("rst_d1_top", 460, 100);
    check_pixel("rst_d1_mid", 460, 200);
    check_pixel("rst_d0_top", 300, 100);
    stream(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
